// File: rtl/id_ex_stage_if.sv
// ID/EX stage bus: ID-side operands/control, downstream forwarding sources, and the EX-side outputs.
// master = surrounding pipeline, slave = id_ex_stage.
interface id_ex_stage_if #(
   parameter int XLEN  = 32,
   parameter int RADDR = 5
);
   logic             hold;
   logic             flush;
   logic             id_valid;
   logic [RADDR-1:0] id_rs1;
   logic [RADDR-1:0] id_rs2;
   logic [RADDR-1:0] id_rd;
   logic [XLEN-1:0]  id_rs1_data;
   logic [XLEN-1:0]  id_rs2_data;
   logic [XLEN-1:0]  id_imm;
   logic [1:0]       id_alu_op;
   logic [2:0]       id_funct3;
   logic             id_funct7b5;
   logic             id_rtype;
   logic             id_alu_src;
   logic [3:0]       id_ctl;
   logic [RADDR-1:0] exmem_rd;
   logic             exmem_we;
   logic [XLEN-1:0]  exmem_res;
   logic [RADDR-1:0] memwb_rd;
   logic             memwb_we;
   logic [XLEN-1:0]  memwb_wdata;
   logic             stall;
   logic             ex_valid;
   logic [XLEN-1:0]  alu_a;
   logic [XLEN-1:0]  alu_b;
   logic [3:0]       alu_ctrl;
   logic [XLEN-1:0]  ex_store;
   logic [RADDR-1:0] ex_rd;
   logic [3:0]       ex_ctl;

   modport master (
      output hold, flush, id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
             id_imm, id_alu_op, id_funct3, id_funct7b5, id_rtype, id_alu_src, id_ctl,
             exmem_rd, exmem_we, exmem_res, memwb_rd, memwb_we, memwb_wdata,
      input  stall, ex_valid, alu_a, alu_b, alu_ctrl, ex_store, ex_rd, ex_ctl
   );

   modport slave (
      input  hold, flush, id_valid, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
             id_imm, id_alu_op, id_funct3, id_funct7b5, id_rtype, id_alu_src, id_ctl,
             exmem_rd, exmem_we, exmem_res, memwb_rd, memwb_we, memwb_wdata,
      output stall, ex_valid, alu_a, alu_b, alu_ctrl, ex_store, ex_rd, ex_ctl
   );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I core: ALU control decode, operand forwarding,
// and load-use hazard detection with bubble insertion.
module id_ex_stage #(
   parameter int XLEN  = 32,
   parameter int RADDR = 5
) (
   input logic           clk,
   input logic           rst_n,
   id_ex_stage_if.slave  bus
);
   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;

   logic             ex_valid;
   logic [RADDR-1:0] ex_rs1;
   logic [RADDR-1:0] ex_rs2;
   logic [RADDR-1:0] ex_rd;
   logic [XLEN-1:0]  ex_rs1_data;
   logic [XLEN-1:0]  ex_rs2_data;
   logic [XLEN-1:0]  ex_imm;
   logic             ex_alu_src;
   logic [3:0]       ex_ctl;
   logic [3:0]       ex_alu_ctrl;

   logic [3:0]       alu_ctrl_next;
   logic             hazard;
   logic             bubble;
   logic [XLEN-1:0]  fwd_rs1;
   logic [XLEN-1:0]  fwd_rs2;

   always_comb begin
      alu_ctrl_next = ALU_ADD;
      case (bus.id_alu_op)
         2'b00: alu_ctrl_next = ALU_ADD;
         2'b01: alu_ctrl_next = ALU_SUB;
         2'b10: begin
            case (bus.id_funct3)
               3'b111:  alu_ctrl_next = ALU_AND;
               3'b110:  alu_ctrl_next = ALU_OR;
               3'b000:  alu_ctrl_next = (bus.id_rtype & bus.id_funct7b5) ? ALU_SUB : ALU_ADD;
               default: alu_ctrl_next = ALU_ADD;
            endcase
         end
         default: alu_ctrl_next = ALU_ADD;
      endcase
   end

   // ex_ctl[2] is mem_read: a load in EX cannot yet supply its data to the instruction in ID
   assign hazard = ex_valid & ex_ctl[2] & (ex_rd != '0)
                 & ((ex_rd == bus.id_rs1) | (ex_rd == bus.id_rs2)) & bus.id_valid;
   assign bubble = bus.flush | (~bus.hold & hazard);
   assign bus.stall = (hazard | bus.hold) & ~bus.flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid    <= 1'b0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_alu_src  <= 1'b0;
         ex_ctl      <= '0;
         ex_alu_ctrl <= ALU_ADD;
      end else if (bubble) begin
         ex_valid    <= 1'b0;
         ex_rs1      <= '0;
         ex_rs2      <= '0;
         ex_rd       <= '0;
         ex_rs1_data <= '0;
         ex_rs2_data <= '0;
         ex_imm      <= '0;
         ex_alu_src  <= 1'b0;
         ex_ctl      <= '0;
         ex_alu_ctrl <= ALU_ADD;
      end else if (!bus.hold) begin
         ex_valid    <= bus.id_valid;
         ex_rs1      <= bus.id_rs1;
         ex_rs2      <= bus.id_rs2;
         ex_rd       <= bus.id_rd;
         ex_rs1_data <= bus.id_rs1_data;
         ex_rs2_data <= bus.id_rs2_data;
         ex_imm      <= bus.id_imm;
         ex_alu_src  <= bus.id_alu_src;
         ex_ctl      <= bus.id_ctl;
         ex_alu_ctrl <= alu_ctrl_next;
      end
   end

   // EX/MEM is the younger producer, so it wins over MEM/WB; x0 is never forwarded
   always_comb begin
      fwd_rs1 = ex_rs1_data;
      if (bus.exmem_we && (bus.exmem_rd != '0) && (bus.exmem_rd == ex_rs1))
         fwd_rs1 = bus.exmem_res;
      else if (bus.memwb_we && (bus.memwb_rd != '0) && (bus.memwb_rd == ex_rs1))
         fwd_rs1 = bus.memwb_wdata;
   end

   always_comb begin
      fwd_rs2 = ex_rs2_data;
      if (bus.exmem_we && (bus.exmem_rd != '0) && (bus.exmem_rd == ex_rs2))
         fwd_rs2 = bus.exmem_res;
      else if (bus.memwb_we && (bus.memwb_rd != '0) && (bus.memwb_rd == ex_rs2))
         fwd_rs2 = bus.memwb_wdata;
   end

   assign bus.ex_valid = ex_valid;
   assign bus.alu_a    = fwd_rs1;
   assign bus.alu_b    = ex_alu_src ? ex_imm : fwd_rs2;
   assign bus.ex_store = fwd_rs2;
   assign bus.alu_ctrl = ex_alu_ctrl;
   assign bus.ex_rd    = ex_rd;
   assign bus.ex_ctl   = ex_valid ? ex_ctl : 4'b0000;
endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: decode, forwarding priority, x0, load-use bubble, hold and flush.
module tb_id_ex_stage;
   logic clk;
   logic rst_n;
   int   passed;
   int   total;

   id_ex_stage_if #(.XLEN(32), .RADDR(5)) bus ();

   id_ex_stage #(.XLEN(32), .RADDR(5)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic zero_inputs();
      bus.hold = 0; bus.flush = 0; bus.id_valid = 0;
      bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
      bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0;
      bus.id_alu_op = 0; bus.id_funct3 = 0; bus.id_funct7b5 = 0; bus.id_rtype = 0;
      bus.id_alu_src = 0; bus.id_ctl = 0;
      bus.exmem_rd = 0; bus.exmem_we = 0; bus.exmem_res = 0;
      bus.memwb_rd = 0; bus.memwb_we = 0; bus.memwb_wdata = 0;
   endtask

   task automatic random_inputs();
      bus.hold = 1'($urandom); bus.flush = 1'($urandom); bus.id_valid = 1'($urandom);
      bus.id_rs1 = 5'($urandom); bus.id_rs2 = 5'($urandom); bus.id_rd = 5'($urandom);
      bus.id_rs1_data = $urandom; bus.id_rs2_data = $urandom; bus.id_imm = $urandom;
      bus.id_alu_op = 2'($urandom); bus.id_funct3 = 3'($urandom);
      bus.id_funct7b5 = 1'($urandom); bus.id_rtype = 1'($urandom);
      bus.id_alu_src = 1'($urandom); bus.id_ctl = 4'($urandom);
      bus.exmem_rd = 5'($urandom); bus.exmem_we = 1'($urandom); bus.exmem_res = $urandom;
      bus.memwb_rd = 5'($urandom); bus.memwb_we = 1'($urandom); bus.memwb_wdata = $urandom;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      rst_n  = 1'b0;
      random_inputs();
      repeat (3) @(posedge clk);
      random_inputs();
      #2;
      chk("reset_valid", 32'(bus.ex_valid), 32'h0);
      chk("reset_ctrl", 32'(bus.alu_ctrl), 32'h2);
      chk("reset_ctl", 32'(bus.ex_ctl), 32'h0);
      zero_inputs();
      #1;
      chk("reset_a", bus.alu_a, 32'h0);
      chk("reset_b", bus.alu_b, 32'h0);
      chk("reset_store", bus.ex_store, 32'h0);
      chk("reset_stall", 32'(bus.stall), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // R-type SUB
      bus.id_valid = 1; bus.id_rs1 = 1; bus.id_rs2 = 2; bus.id_rd = 3;
      bus.id_rs1_data = 32'h100; bus.id_rs2_data = 32'h30; bus.id_ctl = 4'b1000;
      bus.id_alu_op = 2'b10; bus.id_funct3 = 3'b000; bus.id_rtype = 1; bus.id_funct7b5 = 1;
      tick();
      chk("sub_ctrl", 32'(bus.alu_ctrl), 32'h6);
      chk("sub_valid", 32'(bus.ex_valid), 32'h1);
      chk("sub_a", bus.alu_a, 32'h100);
      chk("sub_b", bus.alu_b, 32'h30);
      chk("sub_rd", 32'(bus.ex_rd), 32'h3);
      chk("sub_ctl", 32'(bus.ex_ctl), 32'h8);
      bus.id_funct3 = 3'b111;
      tick();
      chk("and_ctrl", 32'(bus.alu_ctrl), 32'h0);
      bus.id_funct3 = 3'b110;
      tick();
      chk("or_ctrl", 32'(bus.alu_ctrl), 32'h1);
      // addi with funct7b5 set must still be ADD (not R-type)
      bus.id_funct3 = 3'b000; bus.id_rtype = 0; bus.id_alu_src = 1; bus.id_imm = 32'hFFFF_FFFC;
      tick();
      chk("addi_ctrl", 32'(bus.alu_ctrl), 32'h2);
      chk("addi_b", bus.alu_b, 32'hFFFF_FFFC);
      chk("addi_store", bus.ex_store, 32'h30);
      bus.id_alu_op = 2'b01; bus.id_alu_src = 0;
      tick();
      chk("branch_ctrl", 32'(bus.alu_ctrl), 32'h6);
      bus.id_alu_op = 2'b11;
      tick();
      chk("op11_ctrl", 32'(bus.alu_ctrl), 32'h2);
      bus.id_alu_op = 2'b10; bus.id_funct3 = 3'b100;
      tick();
      chk("f3_other_ctrl", 32'(bus.alu_ctrl), 32'h2);

      // forwarding priority
      bus.id_alu_op = 2'b00; bus.id_rs1 = 5; bus.id_rs1_data = 32'h55;
      bus.id_rs2 = 6; bus.id_rs2_data = 32'h66;
      tick();
      bus.exmem_rd = 5; bus.exmem_we = 1; bus.exmem_res = 32'h11;
      bus.memwb_rd = 5; bus.memwb_we = 1; bus.memwb_wdata = 32'h22;
      #1;
      chk("fwd_exmem_wins", bus.alu_a, 32'h11);
      bus.exmem_we = 0;
      #1;
      chk("fwd_memwb", bus.alu_a, 32'h22);
      bus.memwb_we = 0;
      #1;
      chk("fwd_none", bus.alu_a, 32'h55);
      bus.memwb_rd = 6; bus.memwb_we = 1; bus.memwb_wdata = 32'h77;
      #1;
      chk("fwd_b", bus.alu_b, 32'h77);
      chk("fwd_store", bus.ex_store, 32'h77);
      bus.memwb_we = 0;

      // x0 never forwarded
      bus.id_rs1 = 0; bus.id_rs1_data = 0;
      tick();
      bus.exmem_rd = 0; bus.exmem_we = 1; bus.exmem_res = 32'hFF;
      bus.memwb_rd = 0; bus.memwb_we = 1; bus.memwb_wdata = 32'hEE;
      #1;
      chk("x0_no_fwd", bus.alu_a, 32'h0);
      bus.exmem_we = 0; bus.memwb_we = 0;

      // load-use: lw x7 in EX, add x8,x7,x1 in ID
      bus.id_rs1 = 2; bus.id_rs1_data = 32'h1000; bus.id_rs2 = 0; bus.id_rs2_data = 0;
      bus.id_rd = 7; bus.id_ctl = 4'b1101; bus.id_alu_src = 1; bus.id_imm = 32'h4;
      tick();
      chk("lw_ctl", 32'(bus.ex_ctl), 32'hD);
      chk("lw_b", bus.alu_b, 32'h4);
      bus.id_rs1 = 7; bus.id_rs1_data = 32'hDEAD; bus.id_rs2 = 1; bus.id_rs2_data = 32'h10;
      bus.id_rd = 8; bus.id_ctl = 4'b1000; bus.id_alu_src = 0;
      bus.id_alu_op = 2'b10; bus.id_funct3 = 3'b000; bus.id_rtype = 1; bus.id_funct7b5 = 0;
      bus.id_valid = 0;
      #1;
      chk("no_hazard_invalid_id", 32'(bus.stall), 32'h0);
      bus.id_valid = 1;
      #1;
      chk("hazard_stall", 32'(bus.stall), 32'h1);
      tick();
      chk("bubble_valid", 32'(bus.ex_valid), 32'h0);
      chk("bubble_ctl", 32'(bus.ex_ctl), 32'h0);
      chk("bubble_rd", 32'(bus.ex_rd), 32'h0);
      chk("bubble_ctrl", 32'(bus.alu_ctrl), 32'h2);
      chk("stall_released", 32'(bus.stall), 32'h0);
      tick();
      bus.memwb_rd = 7; bus.memwb_we = 1; bus.memwb_wdata = 32'hCAFE;
      #1;
      chk("add_valid", 32'(bus.ex_valid), 32'h1);
      chk("add_rd", 32'(bus.ex_rd), 32'h8);
      chk("add_a_memwb", bus.alu_a, 32'hCAFE);
      chk("add_b", bus.alu_b, 32'h10);
      bus.memwb_we = 0;

      // hold freezes EX, then flush beats hold and hazard
      bus.id_rs1 = 2; bus.id_rs2 = 0; bus.id_rd = 7; bus.id_ctl = 4'b1101;
      bus.id_alu_op = 2'b00;
      tick();
      bus.hold = 1; bus.id_rs1 = 3; bus.id_rd = 9; bus.id_ctl = 4'b1000;
      #1;
      chk("hold_stall", 32'(bus.stall), 32'h1);
      tick();
      chk("hold_ctl", 32'(bus.ex_ctl), 32'hD);
      chk("hold_rd", 32'(bus.ex_rd), 32'h7);
      bus.id_rs1 = 7; bus.flush = 1;
      #1;
      chk("flush_stall", 32'(bus.stall), 32'h0);
      tick();
      chk("flush_valid", 32'(bus.ex_valid), 32'h0);
      chk("flush_ctl", 32'(bus.ex_ctl), 32'h0);
      chk("flush_rd", 32'(bus.ex_rd), 32'h0);

      // asynchronous reset mid-cycle
      bus.hold = 0; bus.flush = 0; bus.id_rs1 = 1; bus.id_rd = 4;
      tick();
      chk("pre_rst_valid", 32'(bus.ex_valid), 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(bus.ex_valid), 32'h0);
      chk("async_rst_rd", 32'(bus.ex_rd), 32'h0);
      rst_n = 1'b1;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
